// File: rtl/persiana_pkg.sv
// Shared definitions for the blind actuator channel.
// Provides the position encoding, the mode encoding and the position stepping helpers.
// The actuator FSM uses the same position constants, so both sides agree on what P means.
package persiana_pkg;

    localparam logic [1:0] POS_BOTTOM  = 2'b00;
    localparam logic [1:0] POS_MID     = 2'b01;
    localparam logic [1:0] POS_TOP     = 2'b10;
    localparam logic [1:0] POS_INVALID = 2'b11;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_SAFE   = 2'b10,
        MODE_FAULT  = 2'b11
    } mode_t;

    // Steps one position towards the top and saturates there.
    function automatic logic [1:0] pos_step_up(input logic [1:0] p);
        return (p == POS_BOTTOM) ? POS_MID : POS_TOP;
    endfunction

    // Steps one position towards the bottom and saturates there.
    function automatic logic [1:0] pos_step_down(input logic [1:0] p);
        return (p == POS_TOP) ? POS_MID : POS_BOTTOM;
    endfunction

endpackage

// File: rtl/persiana_run_watchdog.sv
// Purpose: tick-based saturating run-time counter with a timeout flag for one motor channel.
// Latency: the count updates on the edge after a tick; timeout is a combinational decode of the count.
// Backpressure: none; the counter never stalls and saturates at its maximum instead of wrapping.
// Ports: reloj/reset clock and async active-high reset; tick time base; run motor-active level;
//        timeout high while the count has reached TIMEOUT.
module persiana_run_watchdog #(
    parameter int CW      = 8,
    parameter int TIMEOUT = 20
) (
    input  logic reloj,
    input  logic reset,
    input  logic tick,
    input  logic run,
    output logic timeout
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] run_cnt_d;
    logic [CW-1:0] run_cnt_q;

    // Any cycle with the motor idle clears the count, so only continuous runs accumulate.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (!run) begin
            run_cnt_d = '0;
        end else if (tick && (run_cnt_q != CNT_MAX)) begin
            run_cnt_d = run_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

    assign timeout = (run_cnt_q >= CW'(TIMEOUT));

endmodule

// File: rtl/persiana_scheduler.sv
// Purpose: arbitrates the blind position request P between wind safety, buttons and automatic requests, and latches faults.
// Latency: P, mode and fault are registered, one cycle after the causing input; at_target is combinational.
// Backpressure: none; requests arriving while a higher-priority source owns P are dropped, not queued.
// Ports: reloj/reset clock and async active-high reset; tick time base; btn_up/btn_down button pulses;
//        auto_valid/auto_pos automatic request; wind_alarm level; subir/bajar monitored motor outputs;
//        Ssup/Smed/Sinf end-stop sensors; P position request; mode state; fault latched flag; at_target.
module persiana_scheduler
    import persiana_pkg::*;
#(
    parameter int MANUAL_HOLD = 30,
    parameter int RUN_TIMEOUT = 20,
    parameter int CW          = 8
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       auto_valid,
    input  logic [1:0] auto_pos,
    input  logic       wind_alarm,
    input  logic       subir,
    input  logic       bajar,
    input  logic       Ssup,
    input  logic       Smed,
    input  logic       Sinf,
    output logic [1:0] P,
    output logic [1:0] mode,
    output logic       fault,
    output logic       at_target
);

    mode_t         mode_d, mode_q;
    logic [1:0]    p_d, p_q;
    logic [CW-1:0] hold_cnt_d, hold_cnt_q;
    logic          fault_d, fault_q;

    logic run_timeout;
    logic sensor_bad;
    logic fault_cond;
    logic btn_one;

    persiana_run_watchdog #(
        .CW      (CW),
        .TIMEOUT (RUN_TIMEOUT)
    ) u_run_watchdog (
        .reloj   (reloj),
        .reset   (reset),
        .tick    (tick),
        .run     (subir | bajar),
        .timeout (run_timeout)
    );

    // Top and bottom together is physically impossible; all three high is covered by the same term.
    assign sensor_bad = Ssup & Sinf;
    assign fault_cond = run_timeout | sensor_bad;
    // Both buttons at once is treated as no press at all.
    assign btn_one    = btn_up ^ btn_down;

    always_comb begin
        mode_d     = mode_q;
        p_d        = p_q;
        hold_cnt_d = hold_cnt_q;
        if (mode_q == MODE_FAULT) begin
            // Latched until reset; P stays frozen.
            mode_d = MODE_FAULT;
        end else if (fault_cond) begin
            mode_d = MODE_FAULT;
        end else if (mode_q == MODE_SAFE) begin
            if (!wind_alarm) begin
                mode_d = MODE_AUTO;
            end
        end else if (wind_alarm) begin
            mode_d     = MODE_SAFE;
            p_d        = POS_TOP;
            hold_cnt_d = '0;
        end else if (btn_one) begin
            // The reload also wins over a same-cycle tick decrement.
            mode_d     = MODE_MANUAL;
            p_d        = btn_up ? pos_step_up(p_q) : pos_step_down(p_q);
            hold_cnt_d = CW'(MANUAL_HOLD);
        end else if (mode_q == MODE_MANUAL) begin
            if (tick && (hold_cnt_q != '0)) begin
                hold_cnt_d = hold_cnt_q - CW'(1);
                if (hold_cnt_q == CW'(1)) begin
                    mode_d = MODE_AUTO;
                end
            end
        end else if (auto_valid && (auto_pos != POS_INVALID)) begin
            p_d = auto_pos;
        end
        fault_d = (mode_d == MODE_FAULT);
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_AUTO;
            p_q        <= POS_BOTTOM;
            hold_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            p_q        <= p_d;
            hold_cnt_q <= hold_cnt_d;
            fault_q    <= fault_d;
        end
    end

    assign P     = p_q;
    assign mode  = mode_q;
    assign fault = fault_q;

    always_comb begin
        case (p_q)
            POS_BOTTOM: at_target = Sinf;
            POS_MID:    at_target = Smed;
            POS_TOP:    at_target = Ssup;
            default:    at_target = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_persiana_scheduler.sv
// Bench for persiana_scheduler: directed vector table, hand-written async reset and
// sensor-fault sequences, then randomized traffic checked against a behavioural model.
module tb_persiana_scheduler;

    localparam int MANUAL_HOLD = 30;
    localparam int RUN_TIMEOUT = 20;
    localparam int CW          = 8;

    logic       reloj = 1'b0;
    logic       reset;
    logic       tick, btn_up, btn_down, auto_valid, wind_alarm, subir, bajar;
    logic [1:0] auto_pos;
    logic       Ssup, Smed, Sinf;
    logic [1:0] P, mode;
    logic       fault, at_target;

    int vectors    = 0;
    int miscompares = 0;

    always #5 reloj = ~reloj;

    persiana_scheduler #(
        .MANUAL_HOLD (MANUAL_HOLD),
        .RUN_TIMEOUT (RUN_TIMEOUT),
        .CW          (CW)
    ) dut (
        .reloj      (reloj),
        .reset      (reset),
        .tick       (tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .auto_valid (auto_valid),
        .auto_pos   (auto_pos),
        .wind_alarm (wind_alarm),
        .subir      (subir),
        .bajar      (bajar),
        .Ssup       (Ssup),
        .Smed       (Smed),
        .Sinf       (Sinf),
        .P          (P),
        .mode       (mode),
        .fault      (fault),
        .at_target  (at_target)
    );

    typedef struct {
        int         reps;
        logic       up, dn, av;
        logic [1:0] ap;
        logic       wind, tck, sub;
        logic [2:0] sens;   // {Ssup, Smed, Sinf}
        logic [1:0] ep, em;
        logic       ef;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int reps, logic up, logic dn, logic av, logic [1:0] ap,
                                logic wind, logic tck, logic sub, logic [2:0] sens,
                                logic [1:0] ep, logic [1:0] em, logic ef);
        vec_t v;
        v.reps = reps; v.up = up; v.dn = dn; v.av = av; v.ap = ap;
        v.wind = wind; v.tck = tck; v.sub = sub; v.sens = sens;
        v.ep = ep; v.em = em; v.ef = ef;
        return v;
    endfunction

    task automatic drive(logic up, logic dn, logic av, logic [1:0] ap, logic wind,
                         logic tck, logic sub, logic baj, logic [2:0] sens);
        btn_up = up; btn_down = dn; auto_valid = av; auto_pos = ap;
        wind_alarm = wind; tick = tck; subir = sub; bajar = baj;
        {Ssup, Smed, Sinf} = sens;
    endtask

    task automatic cycle();
        @(posedge reloj);
        #1;
    endtask

    task automatic check(string name, logic [1:0] ep, logic [1:0] em, logic ef);
        vectors++;
        if (P !== ep || mode !== em || fault !== ef) begin
            miscompares++;
            $display("FAIL %s: got P=%b mode=%b fault=%b, expected P=%b mode=%b fault=%b",
                     name, P, mode, fault, ep, em, ef);
        end
    endtask

    // Behavioural reference model: plain integers following the priority rules.
    int m_mode, m_p, m_hold, m_run;

    task automatic model_reset();
        m_mode = 0; m_p = 0; m_hold = 0; m_run = 0;
    endtask

    task automatic model_step(logic up, logic dn, logic av, logic [1:0] ap, logic wind,
                              logic tck, logic sub, logic baj, logic [2:0] sens);
        bit bad;
        bad = (m_run >= RUN_TIMEOUT) || (sens[2] && sens[0]);
        if (m_mode == 3) begin
            // frozen
        end else if (bad) begin
            m_mode = 3;
        end else if (m_mode == 2) begin
            if (!wind) m_mode = 0;
        end else if (wind) begin
            m_mode = 2; m_p = 2; m_hold = 0;
        end else if (up != dn) begin
            if (up) m_p = (m_p + 1 > 2) ? 2 : m_p + 1;
            else    m_p = (m_p - 1 < 0) ? 0 : m_p - 1;
            m_mode = 1; m_hold = MANUAL_HOLD;
        end else if (m_mode == 1) begin
            if (tck) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) m_mode = 0;
            end
        end else if (av && ap != 2'b11) begin
            m_p = int'(ap);
        end
        if (sub || baj) begin
            if (tck && m_run < 255) m_run = m_run + 1;
        end else begin
            m_run = 0;
        end
    endtask

    initial begin
        logic       r_up, r_dn, r_av, r_wind, r_tck, r_sub, r_baj, exp_at;
        logic [1:0] r_ap;
        logic [2:0] r_sens;
        int         fault_age;

        reset = 1'b1;
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000);
        #3;
        check("reset_state", 2'b00, 2'b00, 1'b0);
        reset = 1'b0;

        // Directed table: auto requests, manual stepping and hold, wind, run watchdog.
        tbl.push_back(mk(1,  0,0,1,2'b10, 0,0,0, 3'b000, 2'b10, 2'b00, 0)); // auto to top
        tbl.push_back(mk(1,  0,0,1,2'b11, 0,0,0, 3'b000, 2'b10, 2'b00, 0)); // 11 ignored
        tbl.push_back(mk(1,  0,0,1,2'b00, 0,0,0, 3'b000, 2'b00, 2'b00, 0)); // auto to bottom
        tbl.push_back(mk(1,  1,0,0,2'b00, 0,0,0, 3'b000, 2'b01, 2'b01, 0)); // up
        tbl.push_back(mk(1,  1,0,0,2'b00, 0,0,0, 3'b000, 2'b10, 2'b01, 0)); // up
        tbl.push_back(mk(1,  1,0,0,2'b00, 0,0,0, 3'b000, 2'b10, 2'b01, 0)); // up saturates
        tbl.push_back(mk(1,  0,0,1,2'b00, 0,0,0, 3'b000, 2'b10, 2'b01, 0)); // auto ignored in manual
        tbl.push_back(mk(1,  1,1,0,2'b00, 0,0,0, 3'b000, 2'b10, 2'b01, 0)); // both buttons
        tbl.push_back(mk(1,  0,1,1,2'b00, 0,0,0, 3'b000, 2'b01, 2'b01, 0)); // button beats auto
        tbl.push_back(mk(1,  1,1,0,2'b00, 0,0,0, 3'b000, 2'b01, 2'b01, 0)); // both buttons at mid
        tbl.push_back(mk(29, 0,0,0,2'b00, 0,1,0, 3'b000, 2'b01, 2'b01, 0)); // hold not expired
        tbl.push_back(mk(1,  0,0,0,2'b00, 0,1,0, 3'b000, 2'b01, 2'b00, 0)); // hold expires
        tbl.push_back(mk(1,  0,0,1,2'b00, 0,0,0, 3'b000, 2'b00, 2'b00, 0)); // auto again
        tbl.push_back(mk(1,  0,1,0,2'b00, 0,0,0, 3'b000, 2'b00, 2'b01, 0)); // saturated down press
        tbl.push_back(mk(1,  0,0,0,2'b00, 1,0,0, 3'b000, 2'b10, 2'b10, 0)); // wind -> safe
        tbl.push_back(mk(1,  0,1,1,2'b00, 1,0,0, 3'b000, 2'b10, 2'b10, 0)); // ignored in safe
        tbl.push_back(mk(1,  0,0,0,2'b00, 0,0,0, 3'b000, 2'b10, 2'b00, 0)); // wind clears
        tbl.push_back(mk(19, 0,0,0,2'b00, 0,1,1, 3'b000, 2'b10, 2'b00, 0)); // 19 run ticks
        tbl.push_back(mk(1,  0,0,0,2'b00, 0,1,0, 3'b000, 2'b10, 2'b00, 0)); // gap clears
        tbl.push_back(mk(19, 0,0,0,2'b00, 0,1,1, 3'b000, 2'b10, 2'b00, 0)); // 19 again
        tbl.push_back(mk(1,  0,0,0,2'b00, 0,1,1, 3'b000, 2'b10, 2'b00, 0)); // count reaches 20
        tbl.push_back(mk(1,  0,0,0,2'b00, 0,0,1, 3'b000, 2'b10, 2'b11, 1)); // fault latched
        tbl.push_back(mk(1,  1,0,1,2'b00, 1,1,0, 3'b000, 2'b10, 2'b11, 1)); // all ignored
        tbl.push_back(mk(1,  0,1,0,2'b00, 0,0,0, 3'b000, 2'b10, 2'b11, 1)); // still frozen

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                drive(tbl[i].up, tbl[i].dn, tbl[i].av, tbl[i].ap, tbl[i].wind,
                      tbl[i].tck, tbl[i].sub, 1'b0, tbl[i].sens);
                cycle();
            end
            check($sformatf("vec%0d", i), tbl[i].ep, tbl[i].em, tbl[i].ef);
        end

        // Reset out of FAULT.
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000);
        reset = 1'b1; #2; reset = 1'b0;
        check("reset_from_fault", 2'b00, 2'b00, 1'b0);

        // Impossible sensor combination faults on the next edge.
        drive(0, 0, 1, 2'b10, 0, 0, 0, 0, 3'b000);
        cycle();
        check("auto_top_before_sensor", 2'b10, 2'b00, 1'b0);
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b101);
        cycle();
        check("sensor_fault", 2'b10, 2'b11, 1'b1);
        // Fault wins over a simultaneous wind alarm from a fresh state.
        reset = 1'b1; #2; reset = 1'b0;
        drive(0, 0, 0, 2'b00, 1, 0, 0, 0, 3'b111);
        cycle();
        check("fault_beats_wind", 2'b00, 2'b11, 1'b1);

        // Async reset mid-motion, observed without any clock edge.
        reset = 1'b1; #2; reset = 1'b0;
        drive(0, 0, 1, 2'b01, 0, 1, 1, 0, 3'b000);
        cycle();
        check("moving_mid", 2'b01, 2'b00, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_mid_cycle", 2'b00, 2'b00, 1'b0);
        #1;
        reset = 1'b0;

        // Randomized traffic against the model.
        model_reset();
        r_wind = 0; r_sub = 0; r_baj = 0; fault_age = 0;
        for (int n = 0; n < 3000; n++) begin
            r_up  = ($urandom_range(0, 7) == 0);
            r_dn  = ($urandom_range(0, 7) == 0);
            r_av  = ($urandom_range(0, 3) == 0);
            r_ap  = 2'($urandom_range(0, 3));
            r_tck = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 59) == 0) r_wind = ~r_wind;
            if ($urandom_range(0, 29) == 0) r_sub = ~r_sub;
            if ($urandom_range(0, 39) == 0) r_baj = ~r_baj;
            case ($urandom_range(0, 3))
                0: r_sens = 3'b001;
                1: r_sens = 3'b010;
                2: r_sens = 3'b100;
                default: r_sens = 3'b000;
            endcase
            if ($urandom_range(0, 299) == 0) r_sens = 3'b101;
            drive(r_up, r_dn, r_av, r_ap, r_wind, r_tck, r_sub, r_baj, r_sens);
            model_step(r_up, r_dn, r_av, r_ap, r_wind, r_tck, r_sub, r_baj, r_sens);
            cycle();
            exp_at = (m_p == 0) ? r_sens[0] : (m_p == 1) ? r_sens[1] : r_sens[2];
            vectors++;
            if (P !== 2'(m_p) || mode !== 2'(m_mode) || fault !== (m_mode == 3) || at_target !== exp_at) begin
                miscompares++;
                $display("FAIL rand%0d: got P=%b mode=%b fault=%b at=%b, expected P=%0d mode=%0d fault=%0d at=%b",
                         n, P, mode, fault, at_target, m_p, m_mode, (m_mode == 3), exp_at);
            end
            if (m_mode == 3) fault_age++;
            if (fault_age > 8) begin
                reset = 1'b1; #2; reset = 1'b0;
                model_reset();
                fault_age = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/persiana_scheduler.md
Name: persiana_scheduler

Overview:
Position-command scheduler for the automatic blind actuator FSM. Arbitrates the 2-bit position request P between a wind-safety override, manual up/down buttons and an automatic (light/clock) requester. Supervises the actuator's subir/bajar outputs and the end-stop sensors, and latches a fault on motor over-run or an inconsistent sensor state. Sits between the user/sensor front end and the actuator FSM; it drives that FSM's P input.

Parameters:
MANUAL_HOLD, 30, ticks a manual command overrides automatic requests
RUN_TIMEOUT, 20, maximum ticks subir or bajar may stay continuously high
CW, 8, width of the hold and run counters; must hold max(MANUAL_HOLD, RUN_TIMEOUT)

Ports:
reloj  in  1  clock
reset  in  1  reset, asynchronous, active-high
tick  in  1  one-cycle time-base enable; all timing is counted in ticks
btn_up  in  1  single-cycle pulse (already synchronised/debounced), step up one position
btn_down  in  1  single-cycle pulse, step down one position
auto_valid  in  1  automatic request strobe
auto_pos  in  2  automatic target position
wind_alarm  in  1  level, high while wind is unsafe
subir  in  1  actuator raise output (monitored)
bajar  in  1  actuator lower output (monitored)
Ssup, Smed, Sinf  in  1 each  top, middle and bottom position sensors
P  out  2  registered position request to the actuator: 00 bottom, 01 middle, 10 top
mode  out  2  current state encoding: 00 AUTO, 01 MANUAL, 10 SAFE, 11 FAULT
fault  out  1  registered; high in FAULT
at_target  out  1  combinational; sensor matching P is high (Sinf/Smed/Ssup)

Behaviour:
- Reset (async): P=00, mode=AUTO, fault=0, hold_cnt=0, run_cnt=0. Reset mid-motion clears everything immediately.
- The value 11 is never driven on P. auto_pos=11 is ignored.
- All P and mode updates are registered and visible one cycle after the causing input.
- Per-cycle priority: FAULT > SAFE > buttons > automatic request.
- AUTO: when auto_valid is high and auto_pos is valid, P <= auto_pos.
- Button press in AUTO or MANUAL:
  - btn_up steps P 00->01->10 and saturates at 10.
  - btn_down steps P 10->01->00 and saturates at 00.
  - mode <= MANUAL and hold_cnt <= MANUAL_HOLD, including on a saturated press.
  - btn_up and btn_down high in the same cycle: both ignored; no P change, no hold reload.
  - A button and auto_valid in the same cycle: the button wins.
- MANUAL:
  - auto_valid is ignored.
  - hold_cnt decrements on each tick.
  - When a tick finds hold_cnt==1, mode <= AUTO. P is held until the next automatic request.
- SAFE:
  - Entry: wind_alarm high in AUTO or MANUAL -> mode <= SAFE, P <= 10 (retract), hold_cnt cleared.
  - While in SAFE, buttons and auto requests are ignored.
  - wind_alarm low in SAFE -> mode <= AUTO with P unchanged.
- Run watchdog:
  - run_cnt increments on each tick while (subir|bajar).
  - run_cnt clears in any cycle where both are low.
  - It saturates and does not wrap.
  - If run_cnt reaches RUN_TIMEOUT -> FAULT.
- Sensor check: Ssup&Sinf high, or all three sensors high, in any cycle -> FAULT on the next edge.
- FAULT:
  - fault=1; P is frozen at its last value.
  - All requests are ignored, including wind_alarm.
  - Exit only by reset.
- Simultaneous wind_alarm and a fault condition: FAULT wins.
- tick and a button in the same cycle while in MANUAL: the reload wins over the decrement.

Decomposition:
- Shared package:
  - position constants POS_BOTTOM=00, POS_MID=01, POS_TOP=10.
  - mode encoding MODE_AUTO/MANUAL/SAFE/FAULT.
  - The actuator FSM imports the same position constants.
- Sub-module persiana_run_watchdog (tick-based saturating counter with clear and a timeout flag) is natural. It is reusable for other motorised channels.
- The mode FSM and P register stay in the top module.

Test Plan:
- Reset, then auto_valid with auto_pos=10 -> P=10 one cycle later, mode=00. Then auto_pos=11 -> P stays 10.
- From P=00: btn_up twice, then btn_up a third time -> P=01, 10, 10; mode=01. Then auto_valid with auto_pos=00 during hold -> P stays 10. After MANUAL_HOLD ticks -> mode=00; next auto_valid with 00 -> P=00.
- btn_up and btn_down in the same cycle from P=01 -> P=01 and mode unchanged; auto_valid with 00 in the same cycle as btn_down from P=10 -> P=01, mode MANUAL.
- wind_alarm raised in MANUAL at P=00 -> mode=10, P=10; btn_down ignored. wind_alarm lowered -> mode=00, P=10.
- subir held high for RUN_TIMEOUT=20 ticks -> fault=1, mode=11, P frozen. A gap of one cycle with subir low at tick 19 restarts the count (no fault). Subsequent wind_alarm and buttons have no effect; reset clears all outputs.
- Ssup=Sinf=1 for one cycle -> fault=1 on the next edge. Assert reset while subir is high -> P=00, fault=0 immediately (async).
